// File: rtl/frame_full_ctrl.sv
// ---------------------------------------------------------------------------
// frame_full_ctrl
//
// Per-channel frame-completion tracker for the FFT output memory path.
// Each channel counts pop strobes from the CBFP stage and declares a frame
// complete once frame_len pops have been seen. With LEVEL_MODE=1, completed
// frames are queued, up to PEND_MAX per channel, until the consumer
// acknowledges them. With LEVEL_MODE=0, every completion produces a
// single-cycle pulse on full.
//
// Parameters
//   NUM_CH     number of independent channels
//   CNT_W      width of the pop counter and frame_len
//   PEND_MAX   max completed frames held pending per channel (>= 1)
//   LEVEL_MODE 1 = level/ack handshake, 0 = single-cycle pulse
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous clear of all channel state
//   pop        per-channel pop strobe (one count per cycle high)
//   frame_len  pops per frame, shared by all channels (0 = counting disabled)
//   full_ack   per-channel consumer acknowledge (level mode only)
//   full       per-channel frame-available indicator
//   pend_cnt   pending frames; channel i at [i*PEND_W +: PEND_W]
//   ovf        per-channel sticky overflow
// ---------------------------------------------------------------------------
module frame_full_ctrl #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 5,
    parameter int PEND_MAX   = 2,
    parameter int LEVEL_MODE = 1,
    localparam int PEND_W    = $clog2(PEND_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [NUM_CH-1:0]        pop,
    input  logic [CNT_W-1:0]         frame_len,
    input  logic [NUM_CH-1:0]        full_ack,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH*PEND_W-1:0] pend_cnt,
    output logic [NUM_CH-1:0]        ovf
);

    localparam logic              IS_LEVEL   = (LEVEL_MODE != 0);
    localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic [PEND_W-1:0] pend_q;
        logic [PEND_W-1:0] pend_d;
        logic              full_q;
        logic              full_d;
        logic              ovf_q;
        logic              ovf_d;

        logic              count_en;
        logic [CNT_W:0]    cnt_inc;
        logic              frame_done;
        logic              ack_take;

        // Event decode for this channel. The increment is one bit wider than
        // the counter so that a counter left above a freshly reduced
        // frame_len still compares correctly and completes on the next pop
        // instead of wrapping around.
        always_comb begin
            count_en   = pop[i] && (frame_len != '0);
            cnt_inc    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
            frame_done = count_en && (cnt_inc >= {1'b0, frame_len});
            // An ack only means something if a frame is actually pending.
            ack_take   = IS_LEVEL && full_ack[i] && (pend_q != '0);
        end

        // Next-state logic: clr wins over any activity in the same cycle.
        // In level mode, a completion and a taken ack in the same cycle
        // cancel out, so pend is unchanged and no overflow is flagged even
        // when the queue is at its limit.
        always_comb begin
            cnt_d  = cnt_q;
            pend_d = pend_q;
            full_d = full_q;
            ovf_d  = ovf_q;

            if (clr) begin
                cnt_d  = '0;
                pend_d = '0;
                full_d = 1'b0;
                ovf_d  = 1'b0;
            end else begin
                if (count_en) begin
                    cnt_d = frame_done ? '0 : cnt_inc[CNT_W-1:0];
                end

                if (IS_LEVEL) begin
                    if (frame_done && !ack_take) begin
                        if (pend_q < PEND_LIMIT) begin
                            pend_d = pend_q + PEND_ONE;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (!frame_done && ack_take) begin
                        pend_d = pend_q - PEND_ONE;
                    end
                    full_d = (pend_d != '0);
                end else begin
                    pend_d = '0;
                    ovf_d  = 1'b0;
                    full_d = frame_done;
                end
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                pend_q <= '0;
                full_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
                full_q <= full_d;
                ovf_q  <= ovf_d;
            end
        end

        assign full[i]                       = full_q;
        assign ovf[i]                        = ovf_q;
        assign pend_cnt[i*PEND_W +: PEND_W]  = pend_q;

    end : g_ch

endmodule

// File: tb/tb_frame_full_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_full_ctrl
//
// Drives one level-mode instance and one pulse-mode instance from the same
// stimulus. A behavioural model predicts both instances' outputs for each
// step. The prediction is queued when the step is driven and compared after
// the clock edge that samples it. Directed constant checks at the key points
// back up the model.
// ---------------------------------------------------------------------------
module tb_frame_full_ctrl;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [1:0] pop;
    logic [4:0] frame_len;
    logic [1:0] full_ack;

    logic [1:0] full_l;
    logic [3:0] pend_l;
    logic [1:0] ovf_l;
    logic [1:0] full_p;
    logic [3:0] pend_p;
    logic [1:0] ovf_p;

    int n_checks = 0;
    int n_errors = 0;

    frame_full_ctrl #(
        .NUM_CH(2), .CNT_W(5), .PEND_MAX(2), .LEVEL_MODE(1)
    ) dut_l (
        .clk(clk), .rst(rst), .clr(clr), .pop(pop), .frame_len(frame_len),
        .full_ack(full_ack), .full(full_l), .pend_cnt(pend_l), .ovf(ovf_l)
    );

    frame_full_ctrl #(
        .NUM_CH(2), .CNT_W(5), .PEND_MAX(2), .LEVEL_MODE(0)
    ) dut_p (
        .clk(clk), .rst(rst), .clr(clr), .pop(pop), .frame_len(frame_len),
        .full_ack(full_ack), .full(full_p), .pend_cnt(pend_p), .ovf(ovf_p)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct packed {
        logic [1:0] full_l;
        logic [3:0] pend_l;
        logic [1:0] ovf_l;
        logic [1:0] full_p;
    } exp_t;

    exp_t sb[$];

    int m_cnt[2];
    int m_pend[2];
    bit m_ovf[2];
    bit m_comp[2];

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_cnt[ch]  = 0;
            m_pend[ch] = 0;
            m_ovf[ch]  = 1'b0;
            m_comp[ch] = 1'b0;
        end
    endtask

    // Behavioural prediction of one clock edge for both instances.
    task automatic model_step(input logic [1:0] p, input logic [1:0] a, input logic c);
        int delta;
        for (int ch = 0; ch < 2; ch++) begin
            m_comp[ch] = 1'b0;
            if (c) begin
                m_cnt[ch]  = 0;
                m_pend[ch] = 0;
                m_ovf[ch]  = 1'b0;
            end else begin
                if (p[ch] && frame_len != 0) begin
                    m_cnt[ch] = m_cnt[ch] + 1;
                    if (m_cnt[ch] >= int'(frame_len)) begin
                        m_cnt[ch]  = 0;
                        m_comp[ch] = 1'b1;
                    end
                end
                delta = (m_comp[ch] ? 1 : 0) - ((a[ch] && m_pend[ch] > 0) ? 1 : 0);
                if (delta > 0 && m_pend[ch] == 2) m_ovf[ch] = 1'b1;
                else m_pend[ch] = m_pend[ch] + delta;
            end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.full_l = {m_pend[1] != 0, m_pend[0] != 0};
        e.pend_l = {2'(m_pend[1]), 2'(m_pend[0])};
        e.ovf_l  = {m_ovf[1], m_ovf[0]};
        e.full_p = {m_comp[1], m_comp[0]};
        return e;
    endfunction

    // Pop the oldest prediction and compare it against both instances.
    task automatic checkOutput();
        exp_t e;
        n_checks++;
        assert (sb.size() != 0) else begin
            n_errors++;
            $error("[TB] FAIL sb_empty observed=0 expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("full_l", 8'(full_l), 8'(e.full_l));
            chk("pend_l", 8'(pend_l), 8'(e.pend_l));
            chk("ovf_l",  8'(ovf_l),  8'(e.ovf_l));
            chk("full_p", 8'(full_p), 8'(e.full_p));
            chk("pend_p", 8'(pend_p), 8'd0);
            chk("ovf_p",  8'(ovf_p),  8'd0);
        end
    endtask

    // Drive one cycle of inputs, queue the prediction, then check after the edge.
    task automatic applyStimulus(input logic [1:0] p, input logic [1:0] a, input logic c);
        pop      = p;
        full_ack = a;
        clr      = c;
        model_step(p, a, c);
        sb.push_back(snapshot());
        @(posedge clk);
        #1;
        pop      = 2'b00;
        full_ack = 2'b00;
        clr      = 1'b0;
        checkOutput();
    endtask

    task automatic popN(input logic [1:0] p, input int n);
        for (int k = 0; k < n; k++) applyStimulus(p, 2'b00, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        pop       = 2'b00;
        full_ack  = 2'b00;
        frame_len = 5'd16;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back(snapshot());
        checkOutput();

        // One 16-pop frame on ch0, then ack it.
        popN(2'b01, 15);
        chk("dir_no_full_15", 8'(full_l), 8'd0);
        applyStimulus(2'b01, 2'b00, 1'b0);
        chk("dir_full_16", 8'(full_l), 8'b01);
        chk("dir_pend_16", 8'(pend_l), 8'b0001);
        chk("dir_pulse_16", 8'(full_p), 8'b01);
        applyStimulus(2'b00, 2'b00, 1'b0);
        chk("dir_pulse_drop", 8'(full_p), 8'd0);
        applyStimulus(2'b00, 2'b01, 1'b0);
        chk("dir_ack_full", 8'(full_l), 8'd0);
        chk("dir_ack_pend", 8'(pend_l), 8'd0);

        // Overflow on ch1, then clear.
        frame_len = 5'd4;
        popN(2'b10, 8);
        chk("dir_pend_max", 8'(pend_l), 8'b1000);
        chk("dir_no_ovf_8", 8'(ovf_l), 8'd0);
        popN(2'b10, 4);
        chk("dir_ovf_12", 8'(ovf_l), 8'b10);
        chk("dir_pend_hold", 8'(pend_l), 8'b1000);
        applyStimulus(2'b00, 2'b00, 1'b1);
        chk("dir_clr_pend", 8'(pend_l), 8'd0);
        chk("dir_clr_ovf", 8'(ovf_l), 8'd0);
        chk("dir_clr_full", 8'(full_l), 8'd0);

        // Completion together with ack at PEND_MAX, ack with nothing pending.
        popN(2'b10, 11);
        applyStimulus(2'b10, 2'b10, 1'b0);
        chk("dir_sim_pend", 8'(pend_l), 8'b1000);
        chk("dir_sim_ovf", 8'(ovf_l), 8'd0);
        applyStimulus(2'b00, 2'b01, 1'b0);
        chk("dir_ack_empty", 8'(pend_l), 8'b1000);
        applyStimulus(2'b00, 2'b10, 1'b0);
        chk("dir_ack_ch1", 8'(pend_l), 8'b0100);
        popN(2'b11, 4);
        chk("dir_both_ch", 8'(pend_l), 8'b1001);
        applyStimulus(2'b00, 2'b00, 1'b1);
        popN(2'b01, 3);
        applyStimulus(2'b01, 2'b01, 1'b0);
        chk("dir_ack_at_zero", 8'(pend_l), 8'b0001);

        // Runtime frame_len reduction, then counting disabled.
        applyStimulus(2'b00, 2'b00, 1'b1);
        frame_len = 5'd16;
        popN(2'b01, 10);
        frame_len = 5'd8;
        applyStimulus(2'b01, 2'b00, 1'b0);
        chk("dir_len_cut", 8'(pend_l), 8'b0001);
        popN(2'b01, 7);
        chk("dir_cnt_restart", 8'(pend_l), 8'b0001);
        applyStimulus(2'b01, 2'b00, 1'b0);
        chk("dir_len8_frame", 8'(pend_l), 8'b0010);
        frame_len = 5'd0;
        popN(2'b01, 5);
        chk("dir_len0_pend", 8'(pend_l), 8'b0010);
        chk("dir_len0_pulse", 8'(full_p), 8'd0);

        // frame_len=1 with pop held: continuous pulse.
        applyStimulus(2'b00, 2'b00, 1'b1);
        frame_len = 5'd1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b01, 2'b00, 1'b0);
            chk("dir_pulse_run", 8'(full_p), 8'b01);
        end
        applyStimulus(2'b00, 2'b00, 1'b0);
        chk("dir_pulse_end", 8'(full_p), 8'd0);

        // Asynchronous reset in the middle of a frame.
        applyStimulus(2'b00, 2'b00, 1'b1);
        frame_len = 5'd16;
        popN(2'b01, 16);
        popN(2'b01, 7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        sb.push_back(snapshot());
        checkOutput();
        chk("dir_async_pend", 8'(pend_l), 8'd0);
        chk("dir_async_full", 8'(full_l), 8'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        popN(2'b01, 15);
        chk("dir_fresh_15", 8'(full_l), 8'd0);
        applyStimulus(2'b01, 2'b00, 1'b0);
        chk("dir_fresh_16", 8'(full_l), 8'b01);

        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("[TB] FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
